// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter FSM (IDLE/RUN/MWAIT/BWAIT). Defining BRANCH_TIMEOUT_EN adds a branch-wait timeout.
// Latency: pc updates on the edge after a RUN/MWAIT/BWAIT decision. wr_en is combinational from state and decoder inputs.
// Backpressure: ready!=branch_cond stalls in BWAIT. Decoder inputs are ignored outside RUN, and start is ignored outside IDLE.
module pc_sequencer #(
    parameter int PSIZE      = 6,
    parameter int MUL_CYCLES = 2,
    parameter int TO_BITS    = 4
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic             start,
    input  logic             pc_incr,
    input  logic             pc_abs,
    input  logic             pc_rel,
    input  logic             multi,
    input  logic [PSIZE-1:0] branch_addr,
    input  logic             ready,
    input  logic             branch_cond,
    output logic [PSIZE-1:0] pc,
    output logic             wr_en,
    output logic [1:0]       state,
    output logic             timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        MWAIT = 2'b10,
        BWAIT = 2'b11
    } state_t;

    localparam logic [3:0]       MUL_LOAD = 4'(MUL_CYCLES - 1);
    localparam logic [PSIZE-1:0] PC_ONE   = PSIZE'(1);

    generate
        if (MUL_CYCLES < 2 || MUL_CYCLES > 15) begin : g_bad_mul
            $error("pc_sequencer: MUL_CYCLES must be in 2..15");
        end
        if (TO_BITS < 1) begin : g_bad_to
            $error("pc_sequencer: TO_BITS must be at least 1");
        end
    endgenerate

    state_t           cur;
    logic [3:0]       mul_cnt;
    logic             br_abs;
    logic [PSIZE-1:0] br_addr;
    logic             br_ok;
    logic             is_branch;

    assign state     = cur;
    assign br_ok     = (ready == branch_cond);
    assign is_branch = pc_abs | pc_rel;

`ifdef BRANCH_TIMEOUT_EN
    // The last BWAIT cycle is the one whose count reaches 2^TO_BITS-1 on the next edge.
    localparam logic [TO_BITS-1:0] TO_LAST = TO_BITS'((1 << TO_BITS) - 2);
    logic [TO_BITS-1:0] to_cnt;
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        wr_en = 1'b0;
        case (cur)
            RUN:     wr_en = !is_branch && !multi && pc_incr;
            MWAIT:   wr_en = (mul_cnt == 4'd1);
            default: wr_en = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            cur     <= IDLE;
            pc      <= '0;
            mul_cnt <= '0;
            br_abs  <= 1'b0;
            br_addr <= '0;
`ifdef BRANCH_TIMEOUT_EN
            to_cnt  <= '0;
            timeout <= 1'b0;
`endif
        end else begin
`ifdef BRANCH_TIMEOUT_EN
            timeout <= 1'b0;
`endif
            case (cur)
                IDLE: begin
                    if (start) begin
                        cur <= RUN;
                    end
                end
                RUN: begin
                    if (is_branch) begin
                        if (br_ok) begin
                            pc <= pc_abs ? branch_addr : pc + branch_addr;
                        end else begin
                            br_abs  <= pc_abs;
                            br_addr <= branch_addr;
`ifdef BRANCH_TIMEOUT_EN
                            to_cnt  <= '0;
`endif
                            cur     <= BWAIT;
                        end
                    end else if (multi) begin
                        mul_cnt <= MUL_LOAD;
                        cur     <= MWAIT;
                    end else if (pc_incr) begin
                        pc <= pc + PC_ONE;
                    end
                end
                MWAIT: begin
                    mul_cnt <= mul_cnt - 4'd1;
                    if (mul_cnt == 4'd1) begin
                        pc  <= pc + PC_ONE;
                        cur <= RUN;
                    end
                end
                BWAIT: begin
                    // A status match wins over the timeout when both land on the same cycle.
                    if (br_ok) begin
                        pc  <= br_abs ? br_addr : pc + br_addr;
                        cur <= RUN;
                    end
`ifdef BRANCH_TIMEOUT_EN
                    else if (to_cnt == TO_LAST) begin
                        pc      <= pc + PC_ONE;
                        timeout <= 1'b1;
                        cur     <= RUN;
                    end else begin
                        to_cnt <= to_cnt + TO_BITS'(1);
                    end
`endif
                end
                default: cur <= IDLE;
            endcase
        end
    end

endmodule
